// File: rtl/dram_ar_arbiter_pkg.sv
// Shared constants for the DRAM cache AR arbiter: requester indices, source-tag width
// and FSM state encoding.
package dram_ar_arbiter_pkg;

  localparam int unsigned AXI_ADDR_WIDTH        = 64;
  localparam int unsigned AXI_ID_WIDTH          = 4;
  localparam int unsigned DRAM_AR_ARB_SRC_WIDTH = 2;

  // Requester slots, also used by the R-path demux to decode the ID prefix
  localparam int unsigned REQ_IDX_EXTRACT = 0;
  localparam int unsigned REQ_WB          = 1;
  localparam int unsigned REQ_FILL        = 2;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dram_ar_arbiter_if.sv
// AR-channel bundle between the read requesters, the arbiter and the memory controller,
// including the R-channel snoop used for credit return.
interface dram_ar_arbiter_if
  import dram_ar_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned ADDR_WIDTH      = AXI_ADDR_WIDTH,
  parameter int unsigned ID_WIDTH        = AXI_ID_WIDTH,
  parameter int unsigned SRC_WIDTH       = DRAM_AR_ARB_SRC_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8
);
  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REQ-1:0]            req_arvalid_i;
  logic [NUM_REQ*ID_WIDTH-1:0]   req_arid_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr_i;
  logic [NUM_REQ-1:0]            req_arready_o;
  logic [SRC_WIDTH+ID_WIDTH-1:0] arid_o;
  logic [ADDR_WIDTH-1:0]         araddr_o;
  logic                          arvalid_o;
  logic                          arready_i;
  logic                          rvalid_i;
  logic                          rready_i;
  logic                          rlast_i;
  logic [CNT_WIDTH-1:0]          outstanding_o;

  // Arbiter side: drives the memory-controller AR channel
  modport master (
    input  req_arvalid_i, req_arid_i, req_araddr_i, arready_i, rvalid_i, rready_i, rlast_i,
    output req_arready_o, arid_o, araddr_o, arvalid_o, outstanding_o
  );

  // Environment side: requesters plus memory controller
  modport slave (
    output req_arvalid_i, req_arid_i, req_araddr_i, arready_i, rvalid_i, rready_i, rlast_i,
    input  req_arready_o, arid_o, araddr_o, arvalid_o, outstanding_o
  );

endinterface

// File: rtl/dram_ar_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr_i, with wrap.
module dram_ar_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned SRC_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   valid_i,
  input  logic [SRC_WIDTH-1:0] rr_ptr_i,
  output logic [NUM_REQ-1:0]   grant_oh_c,
  output logic [SRC_WIDTH-1:0] grant_idx_c,
  output logic                 any_c
);

  // Pass one covers [rr_ptr, NUM_REQ); pass two only fires for the wrapped range below it
  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_c && valid_i[k] && (SRC_WIDTH'(k) >= rr_ptr_i)) begin
        any_c         = 1'b1;
        grant_oh_c[k] = 1'b1;
        grant_idx_c   = SRC_WIDTH'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_c && valid_i[k]) begin
        any_c         = 1'b1;
        grant_oh_c[k] = 1'b1;
        grant_idx_c   = SRC_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/dram_ar_arbiter.sv
// Round-robin arbiter sharing the memory-controller AR channel; ID is prefixed with the grant index.
// Optional outstanding-read cap enabled by defining DRAM_AR_ARB_CREDIT_EN.
module dram_ar_arbiter
  import dram_ar_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned ADDR_WIDTH      = AXI_ADDR_WIDTH,
  parameter int unsigned ID_WIDTH        = AXI_ID_WIDTH,
  parameter int unsigned SRC_WIDTH       = DRAM_AR_ARB_SRC_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input logic               clk,
  input logic               rst_n,
  dram_ar_arbiter_if.master bus
);

  localparam int unsigned CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned ARID_WIDTH = SRC_WIDTH + ID_WIDTH;

  arb_state_e                state_q, state_d;
  logic [SRC_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic                      arvalid_q, arvalid_d;
  logic [ARID_WIDTH-1:0]     arid_q, arid_d;
  logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
  logic [NUM_REQ-1:0]        grant_oh_c, req_arready_c;
  logic [SRC_WIDTH-1:0]      grant_idx_c, held_idx_c;
  logic                      any_req_c, credit_ok_c;
  logic [ID_WIDTH-1:0]       sel_id_c;
  logic [ADDR_WIDTH-1:0]     sel_addr_c;

  dram_ar_arbiter_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_rr_pick (
    .valid_i     (bus.req_arvalid_i),
    .rr_ptr_i    (rr_ptr_q),
    .grant_oh_c  (grant_oh_c),
    .grant_idx_c (grant_idx_c),
    .any_c       (any_req_c)
  );

  // One-hot AND-OR mux of the granted requester's ID and address
  always_comb begin
    sel_id_c   = '0;
    sel_addr_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sel_id_c   |= bus.req_arid_i[k*ID_WIDTH +: ID_WIDTH] & {ID_WIDTH{grant_oh_c[k]}};
      sel_addr_c |= bus.req_araddr_i[k*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_oh_c[k]}};
    end
  end

`ifdef DRAM_AR_ARB_CREDIT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ar_hs_c, r_done_c;

  assign ar_hs_c     = arvalid_q & bus.arready_i;
  assign r_done_c    = bus.rvalid_i & bus.rready_i & bus.rlast_i;
  assign credit_ok_c = (cnt_q != CNT_WIDTH'(MAX_OUTSTANDING));

  // Simultaneous issue and return cancel; a return with nothing outstanding is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ar_hs_c && !r_done_c) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end else if (r_done_c && !ar_hs_c && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_WIDTH'(1);
    end
  end

  assign bus.outstanding_o = cnt_q;
`else
  logic unused_r_snoop;
  assign unused_r_snoop    = &{1'b0, bus.rvalid_i, bus.rready_i, bus.rlast_i};
  assign credit_ok_c       = 1'b1;
  assign bus.outstanding_o = CNT_WIDTH'(0);
`endif

  assign held_idx_c = arid_q[ARID_WIDTH-1 -: SRC_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
    end
  end

  // Accept in IDLE, hold the registered request in REQ until the controller takes it
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    arvalid_d     = arvalid_q;
    arid_d        = arid_q;
    araddr_d      = araddr_q;
    req_arready_c = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req_c && credit_ok_c) begin
          req_arready_c = grant_oh_c;
          arid_d        = {grant_idx_c, sel_id_c};
          araddr_d      = sel_addr_c;
          arvalid_d     = 1'b1;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.arready_i) begin
          arvalid_d = 1'b0;
          rr_ptr_d  = (held_idx_c == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : held_idx_c + SRC_WIDTH'(1);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_arready_o = req_arready_c;
  assign bus.arvalid_o     = arvalid_q;
  assign bus.arid_o        = arid_q;
  assign bus.araddr_o      = araddr_q;

endmodule

// File: tb/tb_dram_ar_arbiter.sv
// Bench for dram_ar_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a transaction-level round-robin model.
module tb_dram_ar_arbiter;
  import dram_ar_arbiter_pkg::*;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned MAX_OUT = 2;
`ifdef DRAM_AR_ARB_CREDIT_EN
  localparam bit CREDIT = 1'b1;
`else
  localparam bit CREDIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_ar_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_W), .ID_WIDTH(ID_W),
    .SRC_WIDTH(SRC_W), .MAX_OUTSTANDING(MAX_OUT)
  ) bus ();

  dram_ar_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_W), .ID_WIDTH(ID_W),
    .SRC_WIDTH(SRC_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bit                vld   [NUM_REQ];
  logic [ID_W-1:0]   ids   [NUM_REQ];
  logic [ADDR_W-1:0] addrs [NUM_REQ];

  always_comb begin
    bus.req_arvalid_i = '0;
    bus.req_arid_i    = '0;
    bus.req_araddr_i  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_arvalid_i[k]                  = vld[k];
      bus.req_arid_i[k*ID_W +: ID_W]        = ids[k];
      bus.req_araddr_i[k*ADDR_W +: ADDR_W]  = addrs[k];
    end
  end

  // Reference model state: one registered request at most, pointer, credit count
  bit                     m_busy = 1'b0;
  int                     m_grant = 0;
  int                     m_ptr = 0;
  int                     m_cnt = 0;
  logic [SRC_W+ID_W-1:0]  m_arid = '0;
  logic [ADDR_W-1:0]      m_addr = '0;
  int                     hs_log[$];
  logic [NUM_REQ-1:0]     last_rdy = '0;
  bit                     chk_en = 1'b0;
  int unsigned            p_valid = 0;
  bit                     rnd_io = 1'b0;
  int                     n_checks = 0;
  int                     n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    int g;
    int k;
    bit hs;
    bit rb;
    exp_rdy = '0;
    g = -1;
    if (!m_busy && (!CREDIT || m_cnt < int'(MAX_OUT))) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = (m_ptr + i) % NUM_REQ;
        if (g < 0 && vld[k]) g = k;
      end
    end
    if (g >= 0) exp_rdy = NUM_REQ'(1) << g;
    if (chk_en) begin
      chk("req_arready", 128'(bus.req_arready_o), 128'(exp_rdy));
      chk("arvalid", 128'(bus.arvalid_o), 128'(m_busy));
      if (m_busy) begin
        chk("arid", 128'(bus.arid_o), 128'(m_arid));
        chk("araddr", 128'(bus.araddr_o), 128'(m_addr));
      end
      chk("outstanding", 128'(bus.outstanding_o), 128'(m_cnt));
    end
    last_rdy = bus.req_arready_o;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
    end else begin
      hs = m_busy && bus.arready_i;
      rb = bus.rvalid_i && bus.rready_i && bus.rlast_i;
      if (CREDIT) begin
        if (hs && !rb) m_cnt++;
        else if (rb && !hs && m_cnt > 0) m_cnt--;
      end
      if (hs) begin
        m_busy = 1'b0;
        m_ptr  = (m_grant + 1) % NUM_REQ;
        hs_log.push_back(m_grant);
      end else if (g >= 0) begin
        m_busy  = 1'b1;
        m_grant = g;
        m_arid  = {SRC_W'(g), ids[g]};
        m_addr  = addrs[g];
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  task automatic set_r(input bit b);
    bus.rvalid_i = b;
    bus.rready_i = b;
    bus.rlast_i  = b;
  endtask

  // Advance one cycle; requesters drop a request once its ready pulse was seen
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (last_rdy[k]) vld[k] = 1'b0;
      if (!vld[k] && $urandom_range(99) < p_valid) begin
        vld[k]   = 1'b1;
        ids[k]   = ID_W'($urandom);
        addrs[k] = {$urandom, $urandom};
      end
    end
    if (rnd_io) begin
      bus.arready_i = 1'($urandom_range(1));
      set_r($urandom_range(9) < 3);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic bit any_vld();
    bit a = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) a |= vld[k];
    return a;
  endfunction

  task automatic drain();
    int n = 0;
    p_valid = 0;
    rnd_io = 1'b0;
    bus.arready_i = 1'b1;
    set_r(1'b1);
    while ((any_vld() || bus.arvalid_o) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_done", 128'(n < 300), 128'(1));
    repeat (MAX_OUT + 2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [NUM_REQ];
    int base;
    for (int k = 0; k < NUM_REQ; k++) begin
      vld[k] = 1'b0; ids[k] = '0; addrs[k] = '0;
    end
    bus.arready_i = 1'b0;
    set_r(1'b0);

    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_arvalid", 128'(bus.arvalid_o), 128'(0));
    chk("rst_arid", 128'(bus.arid_o), 128'(0));
    chk("rst_araddr", 128'(bus.araddr_o), 128'(0));
    chk("rst_outstanding", 128'(bus.outstanding_o), 128'(0));
    chk("rst_ready", 128'(bus.req_arready_o), 128'(0));
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    set_r(1'b1);

    // Fairness: all requesters continuously valid
    tick();
    for (int k = 0; k < NUM_REQ; k++) begin
      vld[k] = 1'b1; ids[k] = ID_W'($urandom); addrs[k] = {$urandom, $urandom};
    end
    p_valid = 100;
    bus.arready_i = 1'b1;
    hs_log.delete();
    for (int n = 0; n < 200 && hs_log.size() < 12; n++) tick();
    chk("fair_reached", 128'(hs_log.size() >= 12), 128'(1));
    drain();
    for (int k = 0; k < NUM_REQ; k++) cnt[k] = 0;
    for (int i = 0; i < 12 && i < hs_log.size(); i++) begin
      chk("fair_order", 128'(hs_log[i]), 128'(i % 3));
      cnt[hs_log[i]]++;
    end
    for (int k = 0; k < NUM_REQ; k++) chk("fair_count", 128'(cnt[k]), 128'(4));

    // Single request from requester 1
    tick();
    vld[1] = 1'b1; ids[1] = 4'h3; addrs[1] = 64'h1000;
    bus.arready_i = 1'b1;
    at_neg();
    chk("single_ready", 128'(bus.req_arready_o), 128'(3'b010));
    tick();
    at_neg();
    chk("single_arvalid", 128'(bus.arvalid_o), 128'(1));
    chk("single_araddr", 128'(bus.araddr_o), 128'(64'h1000));
    chk("single_arid", 128'(bus.arid_o), 128'(6'h13));
    chk("single_ready_off", 128'(bus.req_arready_o), 128'(0));
    tick();
    at_neg();
    chk("single_done", 128'(bus.arvalid_o), 128'(0));

    // Backpressure: hold requester 2's request for 5 cycles while requester 0 waits
    tick();
    bus.arready_i = 1'b0;
    vld[0] = 1'b1; ids[0] = 4'h5; addrs[0] = 64'h2000;
    vld[2] = 1'b1; ids[2] = 4'hA; addrs[2] = 64'h3000_0040;
    at_neg();
    chk("bp_ready", 128'(bus.req_arready_o), 128'(3'b100));
    for (int c = 0; c < 5; c++) begin
      tick();
      at_neg();
      chk("bp_arvalid", 128'(bus.arvalid_o), 128'(1));
      chk("bp_araddr", 128'(bus.araddr_o), 128'(64'h3000_0040));
      chk("bp_arid", 128'(bus.arid_o), 128'(6'h2A));
      chk("bp_no_ready", 128'(bus.req_arready_o), 128'(0));
    end
    tick();
    bus.arready_i = 1'b1;
    at_neg();
    chk("bp_still_valid", 128'(bus.arvalid_o), 128'(1));
    tick();
    at_neg();
    chk("bp_released", 128'(bus.arvalid_o), 128'(0));
    chk("bp_next_ready", 128'(bus.req_arready_o), 128'(3'b001));
    tick();
    at_neg();
    chk("bp_next_arid", 128'(bus.arid_o), 128'(6'h05));
    drain();

`ifdef DRAM_AR_ARB_CREDIT_EN
    // Credit cap of 2 with no read data returning
    tick();
    set_r(1'b0);
    bus.arready_i = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      vld[k] = 1'b1; ids[k] = ID_W'($urandom); addrs[k] = {$urandom, $urandom};
    end
    base = hs_log.size();
    repeat (10) tick();
    at_neg();
    chk("credit_hs", 128'(hs_log.size() - base), 128'(2));
    chk("credit_cnt", 128'(bus.outstanding_o), 128'(2));
    chk("credit_block", 128'(bus.req_arready_o), 128'(0));
    tick();
    set_r(1'b1);
    at_neg();
    chk("credit_block2", 128'(bus.req_arready_o), 128'(0));
    tick();
    set_r(1'b0);
    at_neg();
    chk("credit_dec", 128'(bus.outstanding_o), 128'(1));
    chk("credit_resume", 128'(|bus.req_arready_o), 128'(1));
    tick();
    set_r(1'b1);
    at_neg();
    chk("credit_arvalid", 128'(bus.arvalid_o), 128'(1));
    tick();
    set_r(1'b0);
    at_neg();
    chk("credit_simul", 128'(bus.outstanding_o), 128'(1));
    chk("credit_simul_done", 128'(bus.arvalid_o), 128'(0));
    drain();
`endif

    // Reset while a request is held: pointer 1 before reset, so post-reset pick differs
    tick();
    set_r(1'b0);
    bus.arready_i = 1'b1;
    vld[0] = 1'b1; ids[0] = 4'h7; addrs[0] = 64'h4000;
    tick();
    tick();
    bus.arready_i = 1'b0;
    vld[2] = 1'b1; ids[2] = 4'h9; addrs[2] = 64'h5000;
    at_neg();
    chk("rstop_grant", 128'(bus.req_arready_o), 128'(3'b100));
    tick();
    vld[0] = 1'b1; vld[1] = 1'b1;
    rst_n = 1'b0;
    at_neg();
    chk("rstop_held", 128'(bus.arvalid_o), 128'(1));
    tick();
    rst_n = 1'b1;
    at_neg();
    chk("rstop_arvalid", 128'(bus.arvalid_o), 128'(0));
    chk("rstop_outstanding", 128'(bus.outstanding_o), 128'(0));
    chk("rstop_lowest", 128'(bus.req_arready_o), 128'(3'b001));
    drain();

    // Randomized traffic
    p_valid = 40;
    rnd_io = 1'b1;
    repeat (3000) tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_ar_arbiter.md
# dram_ar_arbiter

Round-robin arbiter that shares the single memory-controller AR channel of the DRAM cache controller among NUM_REQ read requesters: index extractor, writeback engine and fill engine. It registers one granted request at a time, prefixes the AXI ID with the requester index so the R-path demux can route responses, and can optionally cap the number of outstanding reads.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..4)
- ADDR_WIDTH, `AXI_ADDR_WIDTH (64), address width
- ID_WIDTH, `AXI_ID_WIDTH, per-requester ID width
- SRC_WIDTH, 2, requester-index width; NUM_REQ <= 2**SRC_WIDTH
- MAX_OUTSTANDING, 8, outstanding-read cap (used only with DRAM_AR_ARB_CREDIT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_arvalid_i  in  NUM_REQ  per-requester AR valid
- req_arid_i  in  NUM_REQ*ID_WIDTH  packed IDs; requester k occupies bits [k*ID_WIDTH +: ID_WIDTH]
- req_araddr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, same packing
- req_arready_o  out  NUM_REQ  one-hot accept pulse
- arid_o  out  SRC_WIDTH+ID_WIDTH  {grant index, requester ID}
- araddr_o  out  ADDR_WIDTH  granted address, unmodified
- arvalid_o  out  1  AR valid to memory controller
- arready_i  in  1  AR ready from memory controller
- rvalid_i, rready_i, rlast_i  in  1 each  R-channel snoop for credit return
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count

## Operation
- States: S_IDLE, S_REQ.
- S_IDLE, when any req_arvalid_i is set and a credit is available:
  - Grant g = first set requester at or after rr_ptr, searching upward with wrap.
  - Assert req_arready_o[g] combinationally in the same cycle.
  - Latch arid_o = {g, id_g} and araddr_o = addr_g.
  - Set arvalid_o next cycle and go to S_REQ.
- S_REQ:
  - req_arready_o = 0.
  - arvalid_o, arid_o and araddr_o hold stable until arready_i.
  - On arready_i: clear arvalid_o, set rr_ptr = (g+1) mod NUM_REQ, go to S_IDLE.
- No request pending, or no credit: stay in S_IDLE and assert no ready.
- Requesters must hold valid, ID and address until their ready pulse, per AXI.
- rr_ptr advances only on a completed handshake, so a granted requester becomes lowest priority.

## Timing
- Reset values: arvalid_o=0, arid_o=0, araddr_o=0, req_arready_o=0, outstanding_o=0, rr_ptr=0, state S_IDLE.
- Accept to arvalid_o: 1 cycle.
- Best throughput: 1 request per 2 cycles (arready_i held high).
- arready_i high while arvalid_o=0 is ignored.
- Reset mid-S_REQ drops the registered request and clears the outstanding count.
- All requesters valid continuously with arready_i=1: grants cycle 0,1,2,0,...

## Configuration
- DRAM_AR_ARB_CREDIT_EN defined:
  - The counter increments on arvalid_o&arready_i.
  - It decrements on rvalid_i&rready_i&rlast_i.
  - Both events in the same cycle leave it unchanged.
  - A decrement at 0 is ignored (saturates).
  - No grant is issued while count == MAX_OUTSTANDING; the grant resumes in the cycle after a decrement.
- DRAM_AR_ARB_CREDIT_EN undefined:
  - No counter and no limit.
  - outstanding_o tied to 0.
  - R-snoop inputs unused.

## Structure
- TYPEDEF.svh holds:
  - DRAM_AR_ARB_SRC_WIDTH.
  - State enum constants S_IDLE, S_REQ.
  - Requester index constants REQ_IDX_EXTRACT=0, REQ_WB=1, REQ_FILL=2, shared with the R demux.
- One sub-module, rr_pick: combinational round-robin priority picker (valid vector, rr_ptr) -> one-hot grant plus index.

## Test plan
- Single request: req 1 valid with addr 0x1000 and id 0x3, arready_i=1. Required: req_arready_o=3'b010 for one cycle; next cycle arvalid_o=1, araddr_o=0x1000, arid_o={2'd1,id 0x3}.
- Backpressure: arready_i low for 5 cycles. Required: arvalid_o, araddr_o and arid_o stable for all 5 cycles; no further req_arready_o pulses.
- Fairness: all three requesters held valid for 12 handshakes. Required: grant order 0,1,2,0,1,2,... and each requester granted 4 times.
- Credit limit (CREDIT_EN, MAX_OUTSTANDING=2): 3 requests with no R beats. Required: exactly 2 handshakes and outstanding_o=2. After one rvalid&rready&rlast, the third request is granted next cycle. Simultaneous AR handshake and rlast leaves the count unchanged.
- Reset mid-op: assert rst_n=0 during S_REQ. Required: next cycle arvalid_o=0, outstanding_o=0 and rr_ptr=0, so the first post-reset grant goes to the lowest valid index.
